// File: rtl/sensor_cond_pkg.sv
// Shared constants and helpers for the sensor-conditioning front end.
package sensor_cond_pkg;

    localparam int unsigned DATA_W      = 12;
    localparam int unsigned ERR_W       = 13;
    localparam int unsigned CAD_W       = 5;
    localparam int unsigned SCALE_W     = 3;
    localparam int unsigned PROD_W      = 20;

    localparam int unsigned CURR_ACC_W  = 14;
    localparam int unsigned TORQ_ACC_W  = 17;
    localparam int unsigned CURR_SHIFT  = 2;
    localparam int unsigned TORQ_SHIFT  = 5;

    localparam int unsigned WIN_W_NORM  = 22;
    localparam int unsigned WIN_W_FAST  = 12;
    localparam int unsigned SMPL_W_NORM = 16;
    localparam int unsigned SMPL_W_FAST = 8;

    localparam logic [DATA_W-1:0] LOW_TORQUE = 12'h380;
    localparam int unsigned       PROD_SHIFT = 6;
    localparam int unsigned       MIN_CAD    = 2;

    // Scale the assist product down and clamp it to the 12-bit current range.
    function automatic logic [DATA_W-1:0] sat_target(input logic [PROD_W-1:0] prod);
        logic [PROD_W-1:0] shifted;
        shifted = prod >> PROD_SHIFT;
        if (|shifted[PROD_W-1:DATA_W]) begin
            return '1;
        end
        return shifted[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sensor_cond_cadence.sv
// Cadence measurement: synchronizes the pedal-magnet pulse and counts rising
// edges per fixed window, producing the cadence rate and a not-pedaling flag.
module cadence_meas
    import sensor_cond_pkg::*;
#(
    parameter int unsigned WIN_W = WIN_W_NORM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cadence_raw_i,
    output logic [CAD_W-1:0] cad_rate_o,
    output logic             not_pedaling_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic             rise_c;
    logic [WIN_W-1:0] win_cnt_q;
    logic             win_end_c;
    logic [CAD_W-1:0] edge_cnt_q;
    logic [CAD_W-1:0] edge_cnt_d;
    logic [CAD_W-1:0] cad_rate_q;
    logic             not_ped_q;

    // Two-flop synchronizer plus a delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= cadence_raw_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise_c = sync2_q & ~sync3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
        end
    end

    assign win_end_c = &win_cnt_q;

    // A rise landing on the window boundary belongs to the new window.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (win_end_c) begin
            edge_cnt_d = rise_c ? CAD_W'(1) : '0;
        end else if (rise_c && !(&edge_cnt_q)) begin
            edge_cnt_d = edge_cnt_q + CAD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            cad_rate_q <= '0;
            not_ped_q  <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            if (win_end_c) begin
                cad_rate_q <= edge_cnt_q;
                not_ped_q  <= (edge_cnt_q < CAD_W'(MIN_CAD));
            end
        end
    end

    assign cad_rate_o     = cad_rate_q;
    assign not_pedaling_o = not_ped_q;

endmodule

// File: rtl/sensor_cond.sv
// Sensor-conditioning top: averages torque and current, forms the assist
// target from torque, cadence and assist level, and drives the PID error.
module sensor_cond
    import sensor_cond_pkg::*;
#(
    parameter int unsigned FAST_SIM = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cadence_raw,
    input  logic [DATA_W-1:0]  torque,
    input  logic [DATA_W-1:0]  curr,
    input  logic [SCALE_W-1:0] scale,
    output logic [ERR_W-1:0]   error,
    output logic               not_pedaling
);

    localparam int unsigned WIN_W  = (FAST_SIM != 0) ? WIN_W_FAST  : WIN_W_NORM;
    localparam int unsigned SMPL_W = (FAST_SIM != 0) ? SMPL_W_FAST : SMPL_W_NORM;

    logic [CAD_W-1:0]      cad_rate_c;
    logic                  not_ped_c;
    logic [SMPL_W-1:0]     smpl_cnt_q;
    logic                  smpl_c;
    logic [CURR_ACC_W-1:0] curr_acc_q;
    logic [CURR_ACC_W-1:0] curr_acc_d;
    logic [TORQ_ACC_W-1:0] torq_acc_q;
    logic [TORQ_ACC_W-1:0] torq_acc_d;
    logic [DATA_W-1:0]     avg_curr_c;
    logic [DATA_W-1:0]     avg_torque_c;
    logic [DATA_W-1:0]     torq_excess_c;
    logic [PROD_W-1:0]     prod_c;
    logic [DATA_W-1:0]     target_d;
    logic [DATA_W-1:0]     target_q;
    logic [ERR_W-1:0]      error_d;
    logic [ERR_W-1:0]      error_q;

    cadence_meas #(
        .WIN_W (WIN_W)
    ) u_cad (
        .clk            (clk),
        .rst_n          (rst_n),
        .cadence_raw_i  (cadence_raw),
        .cad_rate_o     (cad_rate_c),
        .not_pedaling_o (not_ped_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt_q <= '0;
        end else begin
            smpl_cnt_q <= smpl_cnt_q + SMPL_W'(1);
        end
    end

    assign smpl_c = &smpl_cnt_q;

    // Leaky-integrator averagers; steady state is input << shift, so no overflow.
    always_comb begin
        curr_acc_d = curr_acc_q - (curr_acc_q >> CURR_SHIFT) + CURR_ACC_W'(curr);
        torq_acc_d = torq_acc_q - (torq_acc_q >> TORQ_SHIFT) + TORQ_ACC_W'(torque);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_acc_q <= '0;
            torq_acc_q <= '0;
        end else if (smpl_c) begin
            curr_acc_q <= curr_acc_d;
            torq_acc_q <= torq_acc_d;
        end
    end

    assign avg_curr_c   = curr_acc_q[CURR_ACC_W-1:CURR_SHIFT];
    assign avg_torque_c = torq_acc_q[TORQ_ACC_W-1:TORQ_SHIFT];

    // Assist target: torque above the dead-band, weighted by cadence and level.
    always_comb begin
        torq_excess_c = avg_torque_c - LOW_TORQUE;
        prod_c        = PROD_W'(torq_excess_c) * PROD_W'(cad_rate_c) * PROD_W'(scale);
        target_d      = sat_target(prod_c);
        if (not_ped_c || (avg_torque_c <= LOW_TORQUE) || (scale == '0)) begin
            target_d = '0;
        end
    end

    // Both operands are zero-extended 12-bit values, so 13 bits cannot overflow.
    assign error_d = {1'b0, target_q} - {1'b0, avg_curr_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            error_q  <= '0;
        end else begin
            target_q <= target_d;
            error_q  <= error_d;
        end
    end

    assign error        = error_q;
    assign not_pedaling = not_ped_c;

endmodule

// File: doc/sensor_cond.md
# sensor_cond

Sensor-conditioning front end for the eBike drive loop. It turns raw pedal cadence, averaged crank torque and averaged motor current into the signed current `error` and the `not_pedaling` flag that the PID controller consumes. It sits between the A2D interface and the PID: the A2D side supplies torque and current samples, and the outputs drive the PID inputs directly.

## Interface
- `FAST_SIM`, default 0: nonzero shortens both internal timers for simulation.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cadence_raw` in 1: raw pedal-magnet pulse, asynchronous to `clk`.
- `torque` in 12: unsigned crank torque sample from the A2D.
- `curr` in 12: unsigned motor current sample from the A2D.
- `scale` in 3: rider assist level; 0 means no assist.
- `error` out 13: signed error, target current minus average current, registered.
- `not_pedaling` out 1: high when the cadence rate is below threshold, registered.

## Operation
- **Cadence path**
  - `cadence_raw` passes through a 2-flop synchronizer, then a third flop.
  - A rise pulse is generated when flop 2 is high and flop 3 is low.
- **Window timer**
  - Free-running counter, 22 bits (12 bits if `FAST_SIM`).
  - `win_end` asserts when the counter is all ones; the counter then wraps to 0.
- **Edge counter**
  - 5 bits, saturates at 31, increments on each rise pulse.
  - On `win_end`: `cad_rate <= edge_cnt`, and `edge_cnt` clears.
  - Rise coincident with `win_end`: the edge counts toward the new window, so `edge_cnt <= 1`.
- **not_pedaling**
  - Updates only on `win_end`: `not_pedaling <= (edge_cnt < 2)`.
- **Sample tick**
  - 16-bit free-running timer (8 bits if `FAST_SIM`).
  - `smpl` asserts when the timer is all ones.
- **Averaging** (updates only on `smpl`)
  - Current: 14-bit `curr_acc <= curr_acc - (curr_acc>>2) + curr`; `avg_curr = curr_acc[13:2]`.
  - Torque: 17-bit `torq_acc <= torq_acc - (torq_acc>>5) + torque`; `avg_torque = torq_acc[16:5]`.
- **Target** (registered, evaluated every cycle)
  - `target <= 0` if `not_pedaling`, if `avg_torque <= LOW_TORQUE` (12'h380), or if `scale == 0`.
  - Otherwise `prod = (avg_torque - LOW_TORQUE) * cad_rate * scale`, a 20-bit unsigned value.
  - `target <= sat12(prod >> 6)`, where `sat12` returns 12'hFFF if any bit above bit 11 is set.
- **Error** (registered, every cycle)
  - `error <= {1'b0,target} - {1'b0,avg_curr}`, computed in 13-bit two's complement.
  - This range cannot overflow.

## Timing
- **Reset values**
  - `error` = 0, `not_pedaling` = 1.
  - `cad_rate`, `edge_cnt`, both accumulators, `target` and both timers = 0.
  - Synchronizer flops = 0.
- **Cadence latency:** a `cadence_raw` rise reaches the edge counter 3 clocks later.
- **not_pedaling latency:** changes 1 clock after `win_end`.
- **Accumulator to error:** an accumulator update on clock N updates `target` at N+1 and `error` at N+2.
- **Independent timers:** the window and sample timers are unrelated. If `smpl` and `win_end` fall in the same cycle, both actions occur with no priority between them.
- **Reset mid-window:** all state clears asynchronously. The first `not_pedaling` deassertion requires a full window after reset.
- **No handshake:** outputs are continuously valid. The PID samples them on its own decimation strobe.

## Structure
- Package `sensor_cond_pkg` holds:
  - `LOW_TORQUE` = 12'h380;
  - the `PROD_SHIFT` = 6;
  - `MIN_CAD` = 2;
  - the timer widths for normal and `FAST_SIM`.
- Sub-module `cadence_meas` holds:
  - the synchronizer and edge detector;
  - the window timer and saturating edge counter.
- `cadence_meas` outputs `cad_rate[4:0]` and `not_pedaling`.
- The top level contains the sample timer, both averagers, the target arithmetic and the error register.

## Test plan
- **Reset:** all inputs 0 -> `error` = 0 and `not_pedaling` = 1 for at least 2 windows.
- **Cadence counting:** 8 `cadence_raw` pulses per window, with `FAST_SIM` = 1 -> after the first full window `cad_rate` = 8 and `not_pedaling` = 0. Then 1 pulse per window -> `not_pedaling` = 1 one clock after the next `win_end`.
- **Assist:** `torque` = 12'h780, `curr` = 0, `scale` = 4, 8 pulses per window -> after averaging settles, `target` is within 2 LSB of 12'h200 and `error` is within 2 LSB of 13'h0200.
- **Current feedback:** same as the assist scenario plus `curr` = 12'h300 -> `avg_curr` is within 2 LSB of 12'h300 and `error` is within 4 LSB of 13'h1F00 (-256).
- **Saturation:**
  - `torque` = 12'hFFF, more than 31 pulses per window, `scale` = 7 -> `cad_rate` = 31 and `target` = 12'hFFF.
  - A rise coincident with `win_end` -> `edge_cnt` = 1 in the new window.
- **Dead-band and reset:**
  - `torque` = 12'h300 while pedaling -> `target` = 0.
  - `scale` = 0 -> `target` = 0.
  - Assert `rst_n` mid-window -> immediate `error` = 0 and `not_pedaling` = 1.
